fetch_ctrl: RTL and testbench

- Sequencing controller for the fetch-stage program counter.
- Each cycle it arbitrates redirect requests (trap, branch) and stall sources (load-use hazard, icache miss/not-ready) into the single control code the PC register consumes: Default, Branch or Stalled.
- It supplies the redirect target and a front-end flush pulse.
- It holds a redirect that arrives while the icache cannot accept a new address until the icache is ready.

---
 rtl/fetch_ctrl.sv | 132 +++++++++++++
 tb/tb_fetch_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch-stage PC sequencing: arbitrates trap/branch redirects against stalls and
// parks a redirect in HOLD until the icache can take the new address.
module fetch_ctrl #(
  parameter int ADDR_W       = 64,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trap_valid_i,
  input  logic [ADDR_W-1:0] trap_pc_i,
  input  logic              br_valid_i,
  input  logic [ADDR_W-1:0] br_pc_i,
  input  logic              hazard_stall_i,
  input  logic              icache_ready_i,
  input  logic              icache_resp_valid_i,
  output logic [1:0]        ctrl_signal_o,
  output logic [ADDR_W-1:0] pc_new_o,
  output logic              flush_o,
  output logic              redirect_pending_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // state   | meaning
  // ST_RUN  | normal fetch; redirects issue at once when the icache is ready
  // ST_HOLD | redirect latched, stalled until icache_ready_i

  localparam logic [1:0] CTRL_STATE_Default = 2'd0;
  localparam logic [1:0] CTRL_STATE_Branch  = 2'd1;
  localparam logic [1:0] CTRL_STATE_Stalled = 2'd2;
  localparam logic [3:0] FLUSH_INIT         = 4'(FLUSH_CYCLES);

  typedef enum logic {ST_RUN, ST_HOLD} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [3:0]        flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    case (state_q)
      ST_RUN: begin
        if (trap_valid_i && !icache_ready_i) begin
          state_d = ST_HOLD;
          tgt_d   = trap_pc_i;
        end else if (br_valid_i && !icache_ready_i) begin
          state_d = ST_HOLD;
          tgt_d   = br_pc_i;
        end
      end
      ST_HOLD: begin
        if (icache_ready_i)    state_d = ST_RUN;
        else if (trap_valid_i) tgt_d   = trap_pc_i;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    ctrl_signal_o = CTRL_STATE_Default;
    pc_new_o      = '0;
    case (state_q)
      ST_RUN: begin
        if (trap_valid_i) begin
          if (icache_ready_i) begin
            ctrl_signal_o = CTRL_STATE_Branch;
            pc_new_o      = trap_pc_i;
          end else begin
            ctrl_signal_o = CTRL_STATE_Stalled;
          end
        end else if (br_valid_i) begin
          if (icache_ready_i) begin
            ctrl_signal_o = CTRL_STATE_Branch;
            pc_new_o      = br_pc_i;
          end else begin
            ctrl_signal_o = CTRL_STATE_Stalled;
          end
        end else if (hazard_stall_i || !icache_resp_valid_i) begin
          ctrl_signal_o = CTRL_STATE_Stalled;
        end
      end
      ST_HOLD: begin
        if (icache_ready_i) begin
          ctrl_signal_o = CTRL_STATE_Branch;
          pc_new_o      = trap_valid_i ? trap_pc_i : tgt_q;
        end else begin
          ctrl_signal_o = CTRL_STATE_Stalled;
        end
      end
      default: ctrl_signal_o = CTRL_STATE_Stalled;
    endcase
    if (!rst) begin
      ctrl_signal_o = CTRL_STATE_Stalled;
      pc_new_o      = '0;
    end
  end

  // Any redirect seen in RUN is either issued or latched; HOLD keeps the flush armed.
  always_comb begin
    if (state_q == ST_HOLD || trap_valid_i || br_valid_i) flush_cnt_d = FLUSH_INIT;
    else if (flush_cnt_q != 4'd0)                         flush_cnt_d = flush_cnt_q - 4'd1;
    else                                                  flush_cnt_d = flush_cnt_q;

    stall_cnt_d = stall_cnt_q;
    if (ctrl_signal_o == CTRL_STATE_Stalled && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tgt_q       <= '0;
      flush_cnt_q <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      tgt_q       <= tgt_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign flush_o            = (flush_cnt_q != 4'd0);
  assign redirect_pending_o = (state_q == ST_HOLD);
  assign stall_cnt_o        = stall_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed plan scenarios plus random traffic, two instances
// (default parameters, and FLUSH_CYCLES=3 / CNT_W=3) against one behavioural model.
module tb_fetch_ctrl;

  localparam logic [1:0] C_DEF = 2'd0;
  localparam logic [1:0] C_BR  = 2'd1;
  localparam logic [1:0] C_ST  = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_valid, br_valid, hazard, ready, resp_valid;
  logic [63:0] trap_pc, br_pc;

  logic [1:0]  ctrl_a, ctrl_b;
  logic [63:0] pc_a, pc_b;
  logic        flush_a, flush_b, pend_a, pend_b;
  logic [31:0] stall_a;
  logic [2:0]  stall_b;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // model state: one redirect slot shared by both instances, per-instance flush/stall
  bit          m_pend;
  logic [63:0] m_tgt;
  int          m_flush [2];
  longint      m_stall [2];
  int          flush_len [2] = '{1, 3};
  longint      stall_max [2] = '{64'hFFFF_FFFF, 7};

  always #5 clk = ~clk;

  fetch_ctrl #(.ADDR_W(64), .FLUSH_CYCLES(1), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst),
    .trap_valid_i(trap_valid), .trap_pc_i(trap_pc),
    .br_valid_i(br_valid), .br_pc_i(br_pc),
    .hazard_stall_i(hazard), .icache_ready_i(ready), .icache_resp_valid_i(resp_valid),
    .ctrl_signal_o(ctrl_a), .pc_new_o(pc_a), .flush_o(flush_a),
    .redirect_pending_o(pend_a), .stall_cnt_o(stall_a)
  );

  fetch_ctrl #(.ADDR_W(64), .FLUSH_CYCLES(3), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst),
    .trap_valid_i(trap_valid), .trap_pc_i(trap_pc),
    .br_valid_i(br_valid), .br_pc_i(br_pc),
    .hazard_stall_i(hazard), .icache_ready_i(ready), .icache_resp_valid_i(resp_valid),
    .ctrl_signal_o(ctrl_b), .pc_new_o(pc_b), .flush_o(flush_b),
    .redirect_pending_o(pend_b), .stall_cnt_o(stall_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle compare, then advance the model across the coming rising edge.
  always @(negedge clk) begin
    logic [1:0]  ec;
    logic [63:0] ep;
    bit          issue, latch, hold_on;
    ec = C_DEF; ep = '0; issue = 0; latch = 0; hold_on = 0;
    if (chk_en) begin
      if (!rst) begin
        ec = C_ST;
      end else if (m_pend) begin
        if (ready) begin
          ec = C_BR; issue = 1;
          ep = trap_valid ? trap_pc : m_tgt;
        end else begin
          ec = C_ST; hold_on = 1;
        end
      end else if (trap_valid || br_valid) begin
        ep = trap_valid ? trap_pc : br_pc;
        if (ready) begin ec = C_BR; issue = 1; end
        else begin ec = C_ST; latch = 1; end
      end else if (hazard || !resp_valid) begin
        ec = C_ST;
      end

      chk("ctrl_a", 64'(ctrl_a), 64'(ec));
      chk("ctrl_b", 64'(ctrl_b), 64'(ec));
      if (ec == C_BR || !rst) begin
        chk("pc_a", pc_a, ep);
        chk("pc_b", pc_b, ep);
      end
      chk("pend_a", 64'(pend_a), 64'(rst ? m_pend : 1'b0));
      chk("pend_b", 64'(pend_b), 64'(rst ? m_pend : 1'b0));
      chk("flush_a", 64'(flush_a), 64'(rst && m_flush[0] != 0));
      chk("flush_b", 64'(flush_b), 64'(rst && m_flush[1] != 0));
      chk("stall_a", 64'(stall_a), rst ? 64'(m_stall[0] > stall_max[0] ? stall_max[0] : m_stall[0]) : 64'd0);
      chk("stall_b", 64'(stall_b), rst ? 64'(m_stall[1] > stall_max[1] ? stall_max[1] : m_stall[1]) : 64'd0);

      if (!rst) begin
        m_pend = 0; m_tgt = '0;
        for (int i = 0; i < 2; i++) begin m_flush[i] = 0; m_stall[i] = 0; end
      end else begin
        if (latch) m_tgt = ep;
        if (hold_on && trap_valid) m_tgt = trap_pc;
        m_pend = latch || hold_on;
        for (int i = 0; i < 2; i++) begin
          if (issue || latch || hold_on) m_flush[i] = flush_len[i];
          else if (m_flush[i] > 0)       m_flush[i] = m_flush[i] - 1;
          if (ec == C_ST) m_stall[i] = m_stall[i] + 1;
        end
      end
    end
  end

  task automatic idle_inputs();
    trap_valid = 0; br_valid = 0; hazard = 0; ready = 1; resp_valid = 1;
  endtask

  initial begin
    rst = 0; trap_pc = '0; br_pc = '0;
    idle_inputs();
    m_pend = 0; m_tgt = '0;
    for (int i = 0; i < 2; i++) begin m_flush[i] = 0; m_stall[i] = 0; end
    chk_en = 1;
    #2;
    chk("reset_ctrl", 64'(ctrl_a), 64'(C_ST));
    chk("reset_pc", pc_a, 64'd0);
    chk("reset_stall", 64'(stall_a), 64'd0);
    repeat (3) step();
    rst = 1;

    // 1: idle run
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_ctrl", 64'(ctrl_a), 64'(C_DEF));
      chk("idle_flush", 64'(flush_a), 64'd0);
      chk("idle_stall", 64'(stall_a), 64'd0);
    end

    // 2: branch with ready icache
    step(); br_valid = 1; br_pc = 64'h8000_0100; #1;
    chk("br_ctrl", 64'(ctrl_a), 64'(C_BR));
    chk("br_pc", pc_a, 64'h8000_0100);
    step(); br_valid = 0; #1;
    chk("br_flush1_a", 64'(flush_a), 64'd1);
    chk("br_flush1_b", 64'(flush_b), 64'd1);
    step(); #1;
    chk("br_flush2_a", 64'(flush_a), 64'd0);
    chk("br_flush2_b", 64'(flush_b), 64'd1);

    // 3: trap beats branch and hazard
    step(); trap_valid = 1; trap_pc = 64'h8000_0004; br_valid = 1; br_pc = 64'h8000_0200; hazard = 1; #1;
    chk("trap_pri_ctrl", 64'(ctrl_a), 64'(C_BR));
    chk("trap_pri_pc", pc_a, 64'h8000_0004);
    step(); idle_inputs();
    repeat (4) step();

    // 4: branch held while icache busy, trap retargets it
    step(); br_valid = 1; br_pc = 64'h8000_0040; ready = 0; #1;
    chk("hold_req_ctrl", 64'(ctrl_a), 64'(C_ST));
    step(); br_valid = 0; #1;
    chk("hold_pend", 64'(pend_a), 64'd1);
    chk("hold_ctrl", 64'(ctrl_a), 64'(C_ST));
    step(); trap_valid = 1; trap_pc = 64'h8000_0800; #1;
    chk("hold_trap_ctrl", 64'(ctrl_a), 64'(C_ST));
    step(); trap_valid = 0; ready = 1; #1;
    chk("hold_rel_ctrl", 64'(ctrl_a), 64'(C_BR));
    chk("hold_rel_pc", pc_a, 64'h8000_0800);
    step(); #1;
    chk("hold_done_pend", 64'(pend_a), 64'd0);
    chk("hold_done_ctrl", 64'(ctrl_a), 64'(C_DEF));

    // 5: stall counting and saturation
    step(); rst = 0;
    step(); rst = 1;
    step();
    repeat (4) begin hazard = 1; step(); end
    hazard = 0;
    repeat (2) begin resp_valid = 0; step(); end
    idle_inputs(); #1;
    chk("stall6_a", 64'(stall_a), 64'd6);
    chk("stall6_b", 64'(stall_b), 64'd6);
    repeat (4) begin hazard = 1; step(); end
    idle_inputs(); #1;
    chk("stall10_a", 64'(stall_a), 64'd10);
    chk("stall_sat_b", 64'(stall_b), 64'd7);

    // 6: asynchronous reset while holding
    step(); br_valid = 1; br_pc = 64'h8000_0c00; ready = 0;
    step(); br_valid = 0;
    #2 rst = 0;
    #1;
    chk("arst_pend", 64'(pend_a), 64'd0);
    chk("arst_flush", 64'(flush_b), 64'd0);
    chk("arst_ctrl", 64'(ctrl_a), 64'(C_ST));
    chk("arst_stall", 64'(stall_a), 64'd0);
    step(); rst = 1; idle_inputs();
    step(); #1;
    chk("post_rst_pend", 64'(pend_a), 64'd0);
    chk("post_rst_flush", 64'(flush_a), 64'd0);
    chk("post_rst_ctrl", 64'(ctrl_a), 64'(C_DEF));

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      rst        = ($urandom % 200) != 0;
      trap_valid = ($urandom % 8) == 0;
      br_valid   = ($urandom % 4) == 0;
      hazard     = ($urandom % 4) == 0;
      ready      = ($urandom % 3) != 0;
      resp_valid = ($urandom % 5) != 0;
      trap_pc    = {$urandom, $urandom};
      br_pc      = {$urandom, $urandom};
    end
    step(); rst = 1; idle_inputs();
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
